// File: rtl/lms_sample_tx.sv
// rtl/lms_sample_tx.sv - FIFO-buffered serial frame transmitter for LMS filter samples
module lms_sample_tx #(
  parameter int S     = 16,
  parameter int DEPTH = 4,
  parameter int SLOTS = 32,
  parameter int DIV0  = 71,
  parameter int DIV1  = 65
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     mode,
  input  logic                     valid_in,
  input  logic [S-1:0]             data_in,
  input  logic                     clr_flags,
  output logic                     sd_out,
  output logic                     fs_out,
  output logic                     bit_stb,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  output logic                     udf
);

  localparam int AW   = $clog2(DEPTH);
  localparam int DMAX = (DIV0 > DIV1) ? DIV0 : DIV1;
  localparam int DW   = $clog2(DMAX + 1);
  localparam int SW   = $clog2(SLOTS + 1);

  localparam logic [DW-1:0] D0_LAST   = DW'(DIV0 - 1);
  localparam logic [DW-1:0] D1_LAST   = DW'(DIV1 - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SLOTS - 1);
  localparam logic [SW-1:0] DATA_SLOTS = SW'(S);
  localparam logic [AW:0]   FULL      = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [S-1:0]    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     level_q, level_d;
  logic [DW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   slot_q, slot_d;
  logic [S-1:0]    shreg_q, shreg_d;
  logic            sel_q, sel_d;
  logic            sd_q, sd_d, fs_q, fs_d, stb_q, stb_d;
  logic            ovf_q, ovf_d, udf_q, udf_d;
  logic            tick, pop, push;

  assign tick = (state_q == SHIFT) && (cnt_q == (sel_q ? D1_LAST : D0_LAST));
  assign pop  = (state_q == LOAD) && (level_q != '0);
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the write.
  assign push = valid_in && ((level_q != FULL) || pop);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    slot_d   = slot_q;
    shreg_d  = shreg_q;
    sel_d    = sel_q;
    sd_d     = sd_q;
    fs_d     = fs_q;
    stb_d    = 1'b0;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q + (AW + 1)'(push) - (AW + 1)'(pop);
    if (clr_flags) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (valid_in && !push) ovf_d = 1'b1;
    case (state_q)
      IDLE: begin
        sd_d = 1'b0;
        fs_d = 1'b0;
        if (en) state_d = LOAD;
      end
      LOAD: begin
        sel_d   = mode;
        cnt_d   = '0;
        slot_d  = '0;
        state_d = SHIFT;
        if (pop) begin
          shreg_d = mem_q[rd_ptr_q];
        end else begin
          shreg_d = '0;
          udf_d   = 1'b1;
        end
      end
      SHIFT: begin
        cnt_d = tick ? '0 : cnt_q + DW'(1);
        if (tick) begin
          stb_d  = 1'b1;
          fs_d   = (slot_q == '0);
          slot_d = slot_q + SW'(1);
          if (slot_q < DATA_SLOTS) begin
            sd_d    = shreg_q[S-1];
            shreg_d = shreg_q << 1;
          end else begin
            sd_d = 1'b0;
          end
          if (slot_q == SLOT_LAST) state_d = en ? LOAD : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      cnt_q    <= '0;
      slot_q   <= '0;
      shreg_q  <= '0;
      sel_q    <= 1'b0;
      sd_q     <= 1'b0;
      fs_q     <= 1'b0;
      stb_q    <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      slot_q   <= slot_d;
      shreg_q  <= shreg_d;
      sel_q    <= sel_d;
      sd_q     <= sd_d;
      fs_q     <= fs_d;
      stb_q    <= stb_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= data_in;
  end

  assign sd_out  = sd_q;
  assign fs_out  = fs_q;
  assign bit_stb = stb_q;
  assign level   = level_q;
  assign ovf     = ovf_q;
  assign udf     = udf_q;

endmodule

// File: doc/lms_sample_tx.md
LMS_SAMPLE_TX -- requirements
Module: lms_sample_tx

Interface
REQ-001 The block SHALL have parameter S, default 16, meaning sample width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning FIFO depth in samples; a power of two and at least 2.
REQ-003 The block SHALL have parameter SLOTS, default 32, meaning bit slots per frame; SLOTS >= S.
REQ-004 The block SHALL have parameter DIV0, default 71, meaning clk cycles per bit slot when mode=0.
REQ-005 The block SHALL have parameter DIV1, default 65, meaning clk cycles per bit slot when mode=1.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 The block SHALL have port en, input, 1 bit: enables frame transmission.
REQ-009 The block SHALL have port mode, input, 1 bit: bit-rate select between DIV0 and DIV1.
REQ-010 The block SHALL have port valid_in, input, 1 bit: sample strobe from the LMS filter valid_out.
REQ-011 The block SHALL have port data_in, input, S bits: signed sample from the LMS filter out.
REQ-012 The block SHALL have port clr_flags, input, 1 bit: clears the sticky error flags.
REQ-013 The block SHALL have port sd_out, output, 1 bit: serial data, MSB first.
REQ-014 The block SHALL have port fs_out, output, 1 bit: frame sync, high during slot 0 only.
REQ-015 The block SHALL have port bit_stb, output, 1 bit: one-cycle pulse in the cycle sd_out/fs_out update.
REQ-016 The block SHALL have port level, output, clog2(DEPTH)+1 bits: current FIFO occupancy.
REQ-017 The block SHALL have ports ovf and udf, outputs, 1 bit each: sticky overflow and underrun flags.

Function
REQ-018 A valid_in=1 cycle SHALL write data_in into the FIFO when level<DEPTH; when level==DEPTH the sample SHALL be dropped and ovf set.
REQ-019 The divider SHALL count 0..DIV-1, where DIV is selected by mode latched at each frame start; a tick is issued when count==DIV-1, and the count then returns to 0.
REQ-020 The FSM SHALL have states IDLE, LOAD and SHIFT: IDLE->LOAD on en=1; LOAD->SHIFT after one cycle; SHIFT->LOAD after the tick of slot SLOTS-1 when en=1; SHIFT->IDLE after that tick when en=0.
REQ-021 In LOAD, the shifter SHALL pop the FIFO head when level>0; otherwise it SHALL load zero and set udf.
REQ-022 On each tick in SHIFT, the block SHALL drive bit_stb=1 for that cycle and update sd_out/fs_out for the current slot: slots 0..S-1 carry data MSB first, slots S..SLOTS-1 carry 0.
REQ-023 The first tick after LOAD SHALL present slot 0: fs_out=1 and sd_out=MSB; fs_out SHALL return to 0 at the slot 1 tick.
REQ-024 A write and a pop in the same cycle SHALL leave level unchanged and SHALL NOT set ovf, even when level==DEPTH.
REQ-025 FIFO pointers SHALL wrap modulo DEPTH without data loss.
REQ-026 A mode change mid-frame SHALL NOT alter the current frame's slot length; it takes effect at the next LOAD.
REQ-027 Deasserting en mid-frame SHALL complete the current frame before the block enters IDLE.
REQ-028 In IDLE, the block SHALL drive sd_out=0, fs_out=0 and bit_stb=0, and FIFO writes SHALL continue.
REQ-029 clr_flags SHALL clear ovf and udf in the next cycle; a set event in the same cycle SHALL win over the clear.

Reset
REQ-030 When rst=1, the block SHALL within one clk edge empty the FIFO, set level=0, return the FSM to IDLE, and clear the divider, slot counter, sd_out, fs_out, bit_stb, ovf and udf, regardless of state.
REQ-031 A sample presented with valid_in in the reset cycle SHALL be discarded.

Verification
REQ-032 The bench SHALL cover: rst, then en=1 and mode=0, then one valid_in with data_in=0xC001 -> fs_out high for 71 clk, sd_out shows 1100000000000001 over slots 0..15, then 16 zero slots, with bit_stb pulses exactly 71 clk apart.
REQ-033 The bench SHALL cover: en=0 and five valid_in samples 1..5 with DEPTH=4 -> level=4, ovf=1, then enable -> frames carry 1,2,3,4 and sample 5 is absent.
REQ-034 The bench SHALL cover: en=1 with an empty FIFO -> the first frame is all zeros, udf=1; then clr_flags -> udf=0 on the next cycle.
REQ-035 The bench SHALL cover: mode toggled 0->1 in slot 10 -> the current frame keeps 71-clk slots and the next frame uses 65-clk slots.
REQ-036 The bench SHALL cover: rst asserted in slot 7 with level=3 -> the next cycle shows level=0, sd_out=0, fs_out=0 and state IDLE.
REQ-037 The bench SHALL cover: valid_in coincident with the LOAD pop at level=4 -> level stays 4 and ovf stays 0.
